// File: rtl/sb_i2c_bus_master_if.sv
// Command/response and system-bus signals for the I2C hard-block bus master.
// The master modport is the bus-master's own view; slave is the host/bus side.
interface sb_i2c_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic       sbrwi;
    logic       sbstbi;
    logic [7:0] sbadri;
    logic [7:0] sbdati;
    logic [7:0] sbdato;
    logic       sbacko;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, sbdato, sbacko,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
               sbrwi, sbstbi, sbadri, sbdati
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, sbdato, sbacko,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
               sbrwi, sbstbi, sbadri, sbdati
    );
endinterface

// File: rtl/sb_i2c_bus_master.sv
// Single-transfer system-bus master for the hard I2C block (IDLE/STROBE/DONE).
// Define SB_BUS_MASTER_TIMEOUT_EN to bound the wait for sbacko to TIMEOUT_CYCLES strobe cycles.
module sb_i2c_bus_master #(
    parameter logic [3:0]  BUS_ADDR74     = 4'b0001,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      sbclki,
    input  logic                      rst,
    sb_i2c_bus_master_if.master       bus,
    output logic [1:0]                o_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Handshake: a command transfers on an edge where cmd_valid && cmd_ready;
    // rsp_valid is a one-cycle pulse with rsp_rdata/rsp_timeout valid alongside.

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t     r_state;
    logic       r_sbstbi;
    logic       r_sbrwi;
    logic [7:0] r_sbadri;
    logic [7:0] r_sbdati;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
`ifdef SB_BUS_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic        r_rsp_timeout;
    logic [15:0] r_tmo_cnt;
`endif

    always_ff @(posedge sbclki) begin
        if (rst) begin
            r_state       <= IDLE;
            r_sbstbi      <= 1'b0;
            r_sbrwi       <= 1'b0;
            r_sbadri      <= 8'h00;
            r_sbdati      <= 8'h00;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 8'h00;
`ifdef SB_BUS_MASTER_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
            r_tmo_cnt     <= 16'h0000;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_sbrwi   <= bus.cmd_rw;
                        r_sbadri  <= {BUS_ADDR74, bus.cmd_addr};
                        r_sbdati  <= bus.cmd_rw ? bus.cmd_wdata : 8'h00;
                        r_sbstbi  <= 1'b1;
                        r_state   <= STROBE;
`ifdef SB_BUS_MASTER_TIMEOUT_EN
                        r_tmo_cnt <= 16'h0000;
`endif
                    end
                end
                STROBE: begin
                    // An ack on the expiry edge takes priority over the timeout.
                    if (bus.sbacko) begin
                        r_sbstbi      <= 1'b0;
                        r_rsp_rdata   <= r_sbrwi ? 8'h00 : bus.sbdato;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= DONE;
`ifdef SB_BUS_MASTER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_sbstbi      <= 1'b0;
                        r_rsp_rdata   <= 8'h00;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_tmo_cnt     <= r_tmo_cnt + 16'd1;
`endif
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == IDLE) && !rst;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
`ifdef SB_BUS_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = r_rsp_timeout;
`else
    assign bus.rsp_timeout = 1'b0;
`endif
    assign bus.sbrwi     = r_sbrwi;
    assign bus.sbstbi    = r_sbstbi;
    assign bus.sbadri    = r_sbadri;
    assign bus.sbdati    = r_sbdati;
    assign o_state       = r_state;
endmodule

// File: doc/sb_i2c_bus_master.md
SB_I2C_BUS_MASTER -- requirements
Module: sb_i2c_bus_master

Interface
REQ-001 The parameter BUS_ADDR74 SHALL default to 4'b0001 and SHALL be the target IP's upper system-bus address nibble, driven on sbadri[7:4].
REQ-002 The parameter TIMEOUT_CYCLES SHALL default to 255 and SHALL be the maximum number of strobe cycles to wait for an acknowledge (range 1..65535).
REQ-003 sbclki  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-007 cmd_rw  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  4  register offset (low nibble).
REQ-009 cmd_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  8  read data, valid with rsp_valid.
REQ-012 rsp_timeout  out  1  completion was a timeout, valid with rsp_valid.
REQ-013 sbrwi, sbstbi  out  1 each  system-bus read/write select and strobe to the hard I2C block.
REQ-014 sbadri  out  8  bus address; sbdati  out  8  bus write data.
REQ-015 sbdato  in  8  bus read data; sbacko  in  1  bus acknowledge.

Function
REQ-016 The FSM SHALL have three states: IDLE, STROBE and DONE.
REQ-017 cmd_ready SHALL be 1 only in IDLE and SHALL be 0 during rst.
REQ-018 On an accepting edge, the block SHALL register cmd_rw->sbrwi, {BUS_ADDR74,cmd_addr}->sbadri, cmd_wdata (writes) or 8'h00 (reads)->sbdati, set sbstbi=1 and enter STROBE.
REQ-019 sbrwi, sbadri and sbdati SHALL remain stable for the whole of STROBE.
REQ-020 In STROBE, an edge sampling sbacko=1 SHALL clear sbstbi, capture sbdato into rsp_rdata for reads (8'h00 for writes), clear rsp_timeout and enter DONE.
REQ-021 In DONE, rsp_valid SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-022 A write with an ack on the first strobe cycle SHALL complete in 3 cycles, measured from accept edge to the first edge at which cmd_ready is 1 again.
REQ-023 sbacko SHALL be ignored in IDLE and DONE.
REQ-024 rsp_rdata and rsp_timeout SHALL hold their values until the next completion.
REQ-025 cmd_valid SHALL be ignored outside IDLE, and no command SHALL be queued.

Reset
REQ-026 rst SHALL take effect on the next edge regardless of state, including mid-STROBE, and SHALL abandon any transfer in progress without a response.
REQ-027 Reset values SHALL be: state=IDLE, sbstbi=0, sbrwi=0, sbadri=8'h00, sbdati=8'h00, rsp_valid=0, rsp_rdata=8'h00, rsp_timeout=0 and timeout counter=0.

Configuration
REQ-028 The macro SB_BUS_MASTER_TIMEOUT_EN SHALL select the timeout feature.
REQ-029 With SB_BUS_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to STROBE and increment on each STROBE cycle without ack.
REQ-030 With the macro defined, when the counter equals TIMEOUT_CYCLES-1 and sbacko=0, the block SHALL clear sbstbi, set rsp_rdata=8'h00 and rsp_timeout=1, and enter DONE.
REQ-031 With the macro defined, an ack on the same edge as timeout expiry SHALL win, completing as a normal ack.
REQ-032 Without SB_BUS_MASTER_TIMEOUT_EN, no counter logic SHALL be present, STROBE SHALL be held indefinitely until ack, and rsp_timeout SHALL be constant 0.

Verification
REQ-033 Write test: cmd rw=1, addr=4'h8, wdata=8'hA5, ack on 2nd strobe cycle -> sbadri=8'h18, sbdati=8'hA5, sbrwi=1; sbstbi high for 2 cycles; one rsp_valid pulse with rsp_timeout=0.
REQ-034 Read test: cmd rw=0, addr=4'h3, sbdato=8'h5C at ack -> sbadri=8'h13, sbrwi=0; rsp_rdata=8'h5C with rsp_valid; cmd_ready returns to 1 the following cycle.
REQ-035 Back-to-back test: cmd_valid held high for two commands, each acked immediately -> second accept occurs 3 cycles after the first; exactly two rsp_valid pulses, no overlap.
REQ-036 Timeout test (macro on, TIMEOUT_CYCLES=4, no ack) -> sbstbi high exactly 4 cycles; rsp_valid with rsp_timeout=1 and rsp_rdata=8'h00. Same setup with the ack in cycle 4 -> rsp_timeout=0.
REQ-037 Reset test: rst asserted on the 2nd STROBE cycle -> next edge gives sbstbi=0, cmd_ready=0 during rst, no rsp_valid pulse, and all outputs at their REQ-027 values.
REQ-038 Stray-ack test: sbacko=1 while IDLE -> no rsp_valid pulse and no change to rsp_rdata.
